// File: rtl/oc8051_int_resp_if.sv
// rtl/oc8051_int_resp_if.sv - interrupt source / core handshake bundle for oc8051_int_resp
// int_req carries the source's "int" level; "int" is a reserved word in SystemVerilog.
interface oc8051_int_resp_if;
   logic        int_req;
   logic [7:0]  int_v;
   logic        int_pri;
   logic        ie;
   logic        call_req;
   logic [15:0] call_vec;
   logic        call_ack;
   logic        reti;
   logic        int_act;
   logic [1:0]  int_level;
   logic        spur_reti;

   modport slave (
      input  int_req, int_v, int_pri, ie, call_ack, reti,
      output call_req, call_vec, int_act, int_level, spur_reti
   );

   modport master (
      output int_req, int_v, int_pri, ie, call_ack, reti,
      input  call_req, call_vec, int_act, int_level, spur_reti
   );
endinterface

// File: rtl/oc8051_int_resp.sv
// rtl/oc8051_int_resp.sv - vectored interrupt responder with two-level in-service nesting
module oc8051_int_resp #(
   parameter logic [7:0] VEC_HI = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   oc8051_int_resp_if.slave      bus
);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t state;
   logic   pri_reg;
   logic   lo_srv;
   logic   hi_srv;
   logic   lo_nx;
   logic   hi_nx;
   logic   spur_nx;
   logic   eligible;

   assign eligible = bus.ie && bus.int_req &&
                     ((!lo_srv && !hi_srv) || (bus.int_pri && !hi_srv));

   // reti pops the pre-cycle nesting level first; an ack in the same cycle pushes afterwards
   always_comb begin
      lo_nx   = lo_srv;
      hi_nx   = hi_srv;
      spur_nx = 1'b0;
      if (bus.reti) begin
         if (hi_srv)
            hi_nx = 1'b0;
         else if (lo_srv)
            lo_nx = 1'b0;
         else
            spur_nx = 1'b1;
      end
      if (state == REQ && bus.call_ack) begin
         if (pri_reg)
            hi_nx = 1'b1;
         else
            lo_nx = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         bus.call_req  <= 1'b0;
         bus.call_vec  <= 16'h0000;
         bus.spur_reti <= 1'b0;
         pri_reg       <= 1'b0;
         lo_srv        <= 1'b0;
         hi_srv        <= 1'b0;
      end else begin
         lo_srv        <= lo_nx;
         hi_srv        <= hi_nx;
         bus.spur_reti <= spur_nx;
         case (state)
            IDLE: begin
               if (eligible) begin
                  bus.call_vec <= {VEC_HI, bus.int_v};
                  pri_reg      <= bus.int_pri;
                  bus.call_req <= 1'b1;
                  state        <= REQ;
               end
            end
            REQ: begin
               // committed: neither ie nor int dropping withdraws the call
               if (bus.call_ack) begin
                  bus.call_req <= 1'b0;
                  state        <= DRAIN;
               end
            end
            DRAIN: begin
               if (!bus.int_req)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.int_act   = lo_srv | hi_srv;
   assign bus.int_level = {hi_srv, lo_srv};

endmodule

// File: tb/tb_oc8051_int_resp.sv
// tb/tb_oc8051_int_resp.sv - directed self-checking bench for oc8051_int_resp
module tb_oc8051_int_resp;
   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;

   oc8051_int_resp_if bus ();

   oc8051_int_resp #(.VEC_HI(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reti;
      bus.reti = 1'b1;
      tick();
      bus.reti = 1'b0;
   endtask

   // full accept of one request, returning to IDLE with int released
   task automatic grant(input logic [7:0] v, input logic pri);
      bus.int_req = 1'b1; bus.int_v = v; bus.int_pri = pri;
      tick();
      bus.call_ack = 1'b1;
      tick();
      bus.call_ack = 1'b0; bus.int_req = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.int_req = 1'b0; bus.int_v = 8'h00; bus.int_pri = 1'b0; bus.ie = 1'b0;
      bus.call_ack = 1'b0; bus.reti = 1'b0;
      tick(); tick();
      total_cnt++; if (bus.call_req !== 1'b0) $display("FAIL reset_call_req got %b exp 0", bus.call_req); else pass_cnt++;
      total_cnt++; if (bus.call_vec !== 16'h0000) $display("FAIL reset_call_vec got %h exp 0000", bus.call_vec); else pass_cnt++;
      total_cnt++; if (bus.int_level !== 2'b00) $display("FAIL reset_int_level got %b exp 00", bus.int_level); else pass_cnt++;
      total_cnt++; if (bus.int_act !== 1'b0 || bus.spur_reti !== 1'b0) $display("FAIL reset_act_spur got %b%b exp 00", bus.int_act, bus.spur_reti); else pass_cnt++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_low;
      bus.ie = 1'b1; bus.int_req = 1'b1; bus.int_pri = 1'b0; bus.int_v = 8'h40;
      tick();
      total_cnt++; if (bus.call_req !== 1'b1) $display("FAIL low_call_req got %b exp 1", bus.call_req); else pass_cnt++;
      total_cnt++; if (bus.call_vec !== 16'h0040) $display("FAIL low_call_vec got %h exp 0040", bus.call_vec); else pass_cnt++;
      tick();
      total_cnt++; if (bus.call_req !== 1'b1 || bus.int_act !== 1'b0) $display("FAIL low_hold got req=%b act=%b exp req=1 act=0", bus.call_req, bus.int_act); else pass_cnt++;
      bus.call_ack = 1'b1;
      tick();
      bus.call_ack = 1'b0;
      total_cnt++; if (bus.call_req !== 1'b0) $display("FAIL low_ack_req got %b exp 0", bus.call_req); else pass_cnt++;
      total_cnt++; if (bus.int_act !== 1'b1 || bus.int_level !== 2'b01) $display("FAIL low_ack_level got act=%b lvl=%b exp act=1 lvl=01", bus.int_act, bus.int_level); else pass_cnt++;
      bus.int_req = 1'b0;
      tick();
      pulse_reti();
      total_cnt++; if (bus.int_act !== 1'b0 || bus.spur_reti !== 1'b0) $display("FAIL low_reti got act=%b spur=%b exp 0 0", bus.int_act, bus.spur_reti); else pass_cnt++;
      tick();
   endtask

   task automatic test_blocked_low;
      grant(8'h30, 1'b0);
      bus.int_req = 1'b1; bus.int_v = 8'h50; bus.int_pri = 1'b0;
      tick(); tick();
      total_cnt++; if (bus.call_req !== 1'b0) $display("FAIL blocked_low_req got %b exp 0", bus.call_req); else pass_cnt++;
      pulse_reti();
      total_cnt++; if (bus.call_req !== 1'b0 || bus.int_level !== 2'b00) $display("FAIL blocked_after_reti got req=%b lvl=%b exp 0 00", bus.call_req, bus.int_level); else pass_cnt++;
      tick();
      total_cnt++; if (bus.call_req !== 1'b1 || bus.call_vec !== 16'h0050) $display("FAIL blocked_release got req=%b vec=%h exp 1 0050", bus.call_req, bus.call_vec); else pass_cnt++;
      bus.call_ack = 1'b1;
      tick();
      bus.call_ack = 1'b0; bus.int_req = 1'b0;
      tick();
      pulse_reti();
      tick();
   endtask

   task automatic test_preempt;
      grant(8'h30, 1'b0);
      bus.int_req = 1'b1; bus.int_v = 8'h65; bus.int_pri = 1'b1;
      tick();
      total_cnt++; if (bus.call_req !== 1'b1 || bus.call_vec !== 16'h0065) $display("FAIL preempt_req got req=%b vec=%h exp 1 0065", bus.call_req, bus.call_vec); else pass_cnt++;
      bus.call_ack = 1'b1;
      tick();
      bus.call_ack = 1'b0; bus.int_req = 1'b0;
      total_cnt++; if (bus.int_level !== 2'b11) $display("FAIL preempt_level got %b exp 11", bus.int_level); else pass_cnt++;
      tick();
      pulse_reti();
      total_cnt++; if (bus.int_level !== 2'b01) $display("FAIL preempt_reti1 got %b exp 01", bus.int_level); else pass_cnt++;
      pulse_reti();
      total_cnt++; if (bus.int_level !== 2'b00) $display("FAIL preempt_reti2 got %b exp 00", bus.int_level); else pass_cnt++;
      tick();
   endtask

   task automatic test_simultaneous;
      grant(8'h30, 1'b0);
      bus.int_req = 1'b1; bus.int_v = 8'h70; bus.int_pri = 1'b1;
      tick();
      bus.call_ack = 1'b1; bus.reti = 1'b1;
      tick();
      bus.call_ack = 1'b0; bus.reti = 1'b0; bus.int_req = 1'b0;
      total_cnt++; if (bus.int_level !== 2'b10 || bus.spur_reti !== 1'b0) $display("FAIL simul_hi got lvl=%b spur=%b exp 10 0", bus.int_level, bus.spur_reti); else pass_cnt++;
      tick();
      pulse_reti();
      total_cnt++; if (bus.int_level !== 2'b00) $display("FAIL simul_clear got %b exp 00", bus.int_level); else pass_cnt++;
      pulse_reti();
      total_cnt++; if (bus.spur_reti !== 1'b1) $display("FAIL spur_pulse got %b exp 1", bus.spur_reti); else pass_cnt++;
      tick();
      total_cnt++; if (bus.spur_reti !== 1'b0) $display("FAIL spur_one_cycle got %b exp 0", bus.spur_reti); else pass_cnt++;
      bus.int_req = 1'b1; bus.int_v = 8'h11; bus.int_pri = 1'b0;
      tick();
      bus.call_ack = 1'b1; bus.reti = 1'b1;
      tick();
      bus.call_ack = 1'b0; bus.reti = 1'b0; bus.int_req = 1'b0;
      total_cnt++; if (bus.spur_reti !== 1'b1 || bus.int_level !== 2'b01) $display("FAIL simul_spur_push got spur=%b lvl=%b exp 1 01", bus.spur_reti, bus.int_level); else pass_cnt++;
      tick();
      pulse_reti();
      tick();
   endtask

   task automatic test_enable_hold;
      bus.ie = 1'b0; bus.int_req = 1'b1; bus.int_v = 8'h22; bus.int_pri = 1'b0;
      tick(); tick();
      total_cnt++; if (bus.call_req !== 1'b0) $display("FAIL ie_off_req got %b exp 0", bus.call_req); else pass_cnt++;
      bus.ie = 1'b1;
      tick();
      bus.ie = 1'b0;
      tick(); tick();
      total_cnt++; if (bus.call_req !== 1'b1 || bus.call_vec !== 16'h0022) $display("FAIL ie_drop_req got req=%b vec=%h exp 1 0022", bus.call_req, bus.call_vec); else pass_cnt++;
      bus.call_ack = 1'b1; bus.ie = 1'b1;
      tick();
      bus.call_ack = 1'b0;
      pulse_reti();
      tick(); tick();
      total_cnt++; if (bus.call_req !== 1'b0 || bus.int_level !== 2'b00) $display("FAIL drain_hold got req=%b lvl=%b exp 0 00", bus.call_req, bus.int_level); else pass_cnt++;
      bus.int_req = 1'b0;
      tick();
      bus.int_req = 1'b1;
      tick();
      total_cnt++; if (bus.call_req !== 1'b1) $display("FAIL drain_rearm got %b exp 1", bus.call_req); else pass_cnt++;
      bus.call_ack = 1'b1;
      tick();
      bus.call_ack = 1'b0; bus.int_req = 1'b0;
      tick();
      pulse_reti();
      tick();
   endtask

   task automatic test_async_reset;
      grant(8'h33, 1'b0);
      bus.int_req = 1'b1; bus.int_v = 8'h44; bus.int_pri = 1'b1;
      tick();
      total_cnt++; if (bus.call_req !== 1'b1 || bus.int_level !== 2'b01) $display("FAIL arst_pre got req=%b lvl=%b exp 1 01", bus.call_req, bus.int_level); else pass_cnt++;
      #2;
      rst = 1'b1;
      #1;
      total_cnt++; if (bus.call_req !== 1'b0 || bus.int_act !== 1'b0 || bus.call_vec !== 16'h0000) $display("FAIL arst_immediate got req=%b act=%b vec=%h exp 0 0 0000", bus.call_req, bus.int_act, bus.call_vec); else pass_cnt++;
      bus.int_req = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      bus.int_req = 1'b1; bus.int_v = 8'h12; bus.int_pri = 1'b0;
      tick();
      total_cnt++; if (bus.call_req !== 1'b1 || bus.call_vec !== 16'h0012) $display("FAIL arst_idle_after got req=%b vec=%h exp 1 0012", bus.call_req, bus.call_vec); else pass_cnt++;
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      test_reset();
      test_basic_low();
      test_blocked_low();
      test_preempt();
      test_simultaneous();
      test_enable_hold();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/oc8051_int_resp.md
Name: oc8051_int_resp

Overview:
- Core-side responder for the vectored interrupt request pair (int, int_v) driven by board-level interrupt sources.
- Accepts a level request with an 8-bit vector and a priority bit, and raises a held call request to the 8051 core until acknowledged.
- Tracks two-level in-service nesting and retires levels on reti from the core.
- Drives int_act back to the source so the source drops its request.

Parameters:
- VEC_HI, 8'h00, upper byte of the generated call address (call_vec = {VEC_HI, int_v}).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- int  in  1  interrupt request level from source, held until int_act seen
- int_v  in  8  vector low byte, valid while int=1
- int_pri  in  1  request priority: 1=high, 0=low
- ie  in  1  global interrupt enable from core
- call_req  out  1  request to core to perform vectored call
- call_vec  out  16  call target address, stable while call_req=1
- call_ack  in  1  core accepted call (sampled while call_req=1)
- reti  in  1  one-cycle pulse, core executed RETI
- int_act  out  1  any level in service (lo_srv | hi_srv)
- int_level  out  2  {hi_srv, lo_srv}
- spur_reti  out  1  one-cycle pulse, reti with nothing in service

Behaviour:
- Reset (async, rst=1): state=IDLE; call_req=0; call_vec=16'h0000; lo_srv=hi_srv=0; int_act=0; int_level=2'b00; spur_reti=0.
- FSM states: IDLE, REQ, DRAIN.
- IDLE:
  - Eligibility uses registered state of the current cycle: ie=1, int=1, and either (lo_srv=0 and hi_srv=0) or (int_pri=1 and hi_srv=0).
  - When eligible: capture call_vec={VEC_HI,int_v} and pri_reg=int_pri, go to REQ. call_req=1 from the next cycle (1-cycle latency from int to call_req).
  - When not eligible: stay in IDLE. A low request is blocked while anything is in service; a high request is blocked while hi_srv=1.
- REQ:
  - call_req=1; call_vec and pri_reg held stable.
  - ie dropping to 0 does not withdraw the request (it is committed).
  - int dropping also does not withdraw it.
  - On call_ack=1: set hi_srv if pri_reg=1, else set lo_srv; call_req=0 next cycle; go to DRAIN.
- DRAIN: wait for int=0 to prevent re-acceptance of the same held request, then go to IDLE. No timeout.
- reti handling, any state:
  - Clears hi_srv if set, else clears lo_srv.
  - If neither is set: spur_reti=1 for one cycle, no state change.
- Simultaneous call_ack and reti in the same cycle:
  - Pop acts on pre-cycle in-service bits; push is applied after.
  - Example: lo_srv=1 with a high request acked plus reti gives lo_srv=0, hi_srv=1.
  - Example: nothing in service, low acked plus reti gives spur_reti=1, lo_srv=1.
- int_act and int_level are registered-state decodes (combinational from lo_srv/hi_srv). int_act rises the cycle after call_ack.
- Reset mid-REQ: call_req drops immediately (async) and in-service state clears.
- call_ack while not in REQ is ignored.

Test Plan:
- Basic low request: rst released, ie=1, int=1, int_pri=0, int_v=8'h40 → call_req=1 next cycle with call_vec=16'h0040. call_ack at cycle 5 → int_act=1, int_level=2'b01. Source drops int → IDLE. reti → int_act=0.
- Blocked low: lo_srv=1, second low request int_v=8'h50 → call_req stays 0. After reti and int still 1 → call_vec=16'h0050, call_req=1.
- Preemption: lo_srv=1, high request int_v=8'h65 → call_vec=16'h0065; ack → int_level=2'b11. First reti → 2'b01; second reti → 2'b00.
- Simultaneous events: lo_srv=1, REQ high, call_ack and reti in the same cycle → int_level=2'b10, spur_reti=0. Also reti with int_level=2'b00 → spur_reti pulse=1.
- Enable/hold: ie=0 with int=1 → no call_req. ie=1 then ie=0 during REQ → call_req stays 1 until ack. With int held after ack → no second call_req until int=0 then 1.
- Async reset mid-REQ (call_req=1, lo_srv=1): assert rst between clock edges → call_req=0, int_act=0 immediately. Release → IDLE.
